// File: rtl/bp_be_host_mmio_monitor.sv
// Watches committed stores for host MMIO: test status, console print FIFO, instruction count and a no-commit watchdog.
// Status and counters register one cycle after the commit. The print FIFO drops entries and flags overflow when full without a same-cycle dequeue.
module bp_be_host_mmio_monitor #(
  parameter int print_fifo_els_p = 4,
  parameter int timeout_cycles_p = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmt_v_i,
  input  logic        cmt_store_v_i,
  input  logic [63:0] cmt_addr_i,
  input  logic [63:0] cmt_data_i,
  output logic        print_v_o,
  output logic [7:0]  print_data_o,
  output logic        print_is_int_o,
  input  logic        print_yumi_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        err_o,
  output logic [15:0] test_num_o,
  output logic [63:0] instr_count_o,
  output logic        timeout_o,
  output logic        overflow_o
);

  localparam int ptr_w_lp = $clog2(print_fifo_els_p);
  localparam int wd_w_lp  = $clog2(timeout_cycles_p + 1);
  localparam logic [63:0] status_addr_lp = 64'h0000_0000_C00D_EAD0;
  localparam logic [63:0] int_addr_lp    = 64'h0000_0000_8FFF_FFFF;
  localparam logic [63:0] char_addr_lp   = 64'h0000_0000_8FFF_EFFF;
  localparam logic [ptr_w_lp-1:0] ptr_one_lp = 1;
  localparam logic [wd_w_lp-1:0]  wd_max_lp  = wd_w_lp'(timeout_cycles_p);

  typedef enum logic {RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic                pass_q, pass_d, fail_q, fail_d, err_q, err_d;
  logic [15:0]         test_num_q, test_num_d;
  logic [63:0]         instr_count_q, instr_count_d;
  logic [wd_w_lp-1:0]  wd_q, wd_d;
  logic                timeout_q, timeout_d, overflow_q, overflow_d;
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                full_q, full_d;
  logic [8:0]          mem_q [print_fifo_els_p];

  logic running, host_st, status_hit, int_hit, char_hit, enq_req, enq, deq, empty;

  always_comb begin
    running    = (state_q == RUN);
    host_st    = cmt_v_i & cmt_store_v_i;
    status_hit = running & host_st & (cmt_addr_i == status_addr_lp);
    int_hit    = running & host_st & (cmt_addr_i == int_addr_lp);
    char_hit   = running & host_st & (cmt_addr_i == char_addr_lp);
    enq_req    = int_hit | char_hit;
    empty      = (wr_ptr_q == rd_ptr_q) & ~full_q;
    deq        = print_yumi_i & ~empty;
    // A full FIFO still takes the new entry when the head leaves this same cycle.
    enq        = enq_req & (~full_q | deq);
  end

  always_comb begin
    state_d       = state_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    err_d         = err_q;
    test_num_d    = test_num_q;
    instr_count_d = instr_count_q;
    wd_d          = wd_q;
    timeout_d     = timeout_q;
    overflow_d    = overflow_q | (enq_req & ~enq);
    wr_ptr_d      = enq ? wr_ptr_q + ptr_one_lp : wr_ptr_q;
    rd_ptr_d      = deq ? rd_ptr_q + ptr_one_lp : rd_ptr_q;
    full_d        = full_q;
    if (enq && !deq && (wr_ptr_d == rd_ptr_q)) full_d = 1'b1;
    else if (deq && !enq) full_d = 1'b0;

    if (running) begin
      if (cmt_v_i) instr_count_d = instr_count_q + 64'd1;
      if (cmt_v_i) wd_d = '0;
      else if (wd_q != wd_max_lp) wd_d = wd_q + 1'b1;
      if (wd_q == wd_max_lp) timeout_d = 1'b1;
      if (status_hit) begin
        state_d    = DONE;
        test_num_d = cmt_data_i[15:0];
        pass_d     = (cmt_data_i[31:16] == 16'h0000);
        fail_d     = (cmt_data_i[31:16] == 16'hFFFF);
        err_d      = (cmt_data_i[31:16] != 16'h0000) & (cmt_data_i[31:16] != 16'hFFFF);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= RUN;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      err_q         <= 1'b0;
      test_num_q    <= '0;
      instr_count_q <= '0;
      wd_q          <= '0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      full_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      err_q         <= err_d;
      test_num_q    <= test_num_d;
      instr_count_q <= instr_count_d;
      wd_q          <= wd_d;
      timeout_q     <= timeout_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      full_q        <= full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && enq) mem_q[wr_ptr_q] <= {int_hit, cmt_data_i[7:0]};
  end

  // Outputs are forced low for the whole time reset is held, not only after the first edge.
  always_comb begin
    print_v_o      = ~reset_i & ~empty;
    print_is_int_o = ~reset_i & ~empty & mem_q[rd_ptr_q][8];
    print_data_o   = (reset_i | empty) ? 8'h00 : mem_q[rd_ptr_q][7:0];
    done_o         = ~reset_i & (state_q == DONE);
    pass_o         = ~reset_i & pass_q;
    fail_o         = ~reset_i & fail_q;
    err_o          = ~reset_i & err_q;
    test_num_o     = reset_i ? 16'h0 : test_num_q;
    instr_count_o  = reset_i ? 64'h0 : instr_count_q;
    timeout_o      = ~reset_i & timeout_q;
    overflow_o     = ~reset_i & overflow_q;
  end

endmodule

// File: tb/tb_bp_be_host_mmio_monitor.sv
// Directed bench for bp_be_host_mmio_monitor: status decode, print FIFO, counters, watchdog and reset.
module tb_bp_be_host_mmio_monitor;

  localparam logic [63:0] STAT = 64'h0000_0000_C00D_EAD0;
  localparam logic [63:0] PINT = 64'h0000_0000_8FFF_FFFF;
  localparam logic [63:0] PCHR = 64'h0000_0000_8FFF_EFFF;
  localparam logic [63:0] OTHR = 64'h0000_0000_8000_1000;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmt_v_i = 1'b0, cmt_store_v_i = 1'b0, print_yumi_i = 1'b0;
  logic [63:0] cmt_addr_i = '0, cmt_data_i = '0;
  logic        print_v_o, print_is_int_o, done_o, pass_o, fail_o, err_o, timeout_o, overflow_o;
  logic [7:0]  print_data_o;
  logic [15:0] test_num_o;
  logic [63:0] instr_count_o;

  int n_checks = 0;
  int n_errors = 0;

  bp_be_host_mmio_monitor #(.print_fifo_els_p(4), .timeout_cycles_p(1024)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmt_v_i(cmt_v_i), .cmt_store_v_i(cmt_store_v_i),
    .cmt_addr_i(cmt_addr_i), .cmt_data_i(cmt_data_i),
    .print_v_o(print_v_o), .print_data_o(print_data_o),
    .print_is_int_o(print_is_int_o), .print_yumi_i(print_yumi_i),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .err_o(err_o),
    .test_num_o(test_num_o), .instr_count_o(instr_count_o),
    .timeout_o(timeout_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic st, input logic [63:0] a,
                     input logic [63:0] d, input logic y);
    cmt_v_i = v; cmt_store_v_i = st; cmt_addr_i = a; cmt_data_i = d; print_yumi_i = y;
    @(posedge clk_i); #1;
    cmt_v_i = 1'b0; cmt_store_v_i = 1'b0; cmt_addr_i = '0; cmt_data_i = '0; print_yumi_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  task automatic head(input string tag, input logic v, input logic is_int, input logic [7:0] d);
    check({tag, "_v"}, 64'(print_v_o), 64'(v));
    if (v) begin
      check({tag, "_int"}, 64'(print_is_int_o), 64'(is_int));
      check({tag, "_dat"}, 64'(print_data_o), 64'(d));
    end
  endtask

  initial begin
    #1;
    check("rst_hold_done", 64'(done_o), 64'd0);
    do_reset();
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_count", instr_count_o, 64'd0);
    check("rst_pv", 64'(print_v_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);

    // pass path, counting and sticky DONE
    cyc(1, 0, 64'd0, 64'd0, 0);
    cyc(1, 1, OTHR, 64'h55, 0);
    cyc(1, 0, 64'd0, 64'd0, 0);
    check("cnt3", instr_count_o, 64'd3);
    check("pre_done", 64'(done_o), 64'd0);
    cyc(1, 1, STAT, 64'h0000_0005, 0);
    check("p_done", 64'(done_o), 64'd1);
    check("p_pass", 64'(pass_o), 64'd1);
    check("p_fail", 64'(fail_o), 64'd0);
    check("p_err", 64'(err_o), 64'd0);
    check("p_tnum", 64'(test_num_o), 64'h5);
    check("p_cnt", instr_count_o, 64'd4);
    cyc(1, 0, 64'd0, 64'd0, 0);
    cyc(1, 1, PINT, 64'h33, 0);
    cyc(1, 1, STAT, 64'hFFFF_0009, 0);
    check("done_cnt", instr_count_o, 64'd4);
    check("done_noenq", 64'(print_v_o), 64'd0);
    check("done_sticky_pass", 64'(pass_o), 64'd1);
    check("done_sticky_fail", 64'(fail_o), 64'd0);
    check("done_sticky_tnum", 64'(test_num_o), 64'h5);

    // fail and err codes
    do_reset();
    cyc(1, 1, STAT, 64'hFFFF_0002, 0);
    check("f_fail", 64'(fail_o), 64'd1);
    check("f_pass", 64'(pass_o), 64'd0);
    check("f_tnum", 64'(test_num_o), 64'h2);
    do_reset();
    cyc(1, 1, STAT, 64'h1234_0001, 0);
    check("e_err", 64'(err_o), 64'd1);
    check("e_pass", 64'(pass_o), 64'd0);
    check("e_fail", 64'(fail_o), 64'd0);
    check("e_tnum", 64'(test_num_o), 64'h1);

    // print ordering and dequeue
    do_reset();
    cyc(1, 1, PCHR, 64'h41, 0);
    head("o1", 1, 0, 8'h41);
    cyc(1, 1, PINT, 64'hAB07, 0);
    head("o2", 1, 0, 8'h41);
    cyc(0, 0, 64'd0, 64'd0, 1);
    head("o3", 1, 1, 8'h07);
    cyc(0, 0, 64'd0, 64'd0, 1);
    head("o4", 0, 0, 8'h00);
    cyc(0, 0, 64'd0, 64'd0, 1);
    head("o5_illegal_yumi", 0, 0, 8'h00);
    cyc(1, 1, PINT, 64'h5A, 1);
    head("byp", 1, 1, 8'h5A);

    // overflow: fifth store dropped
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1, 1, PINT, 64'(i), 0);
    check("ovf_set", 64'(overflow_o), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      head($sformatf("ovf_h%0d", i), 1, 1, 8'(i));
      cyc(0, 0, 64'd0, 64'd0, 1);
    end
    head("ovf_empty", 0, 0, 8'h00);

    // full FIFO accepts an enqueue paired with a dequeue
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, PCHR, 64'(8'h10 + i), 0);
    cyc(1, 1, PCHR, 64'h14, 1);
    check("fy_ovf", 64'(overflow_o), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      head($sformatf("fy_h%0d", i), 1, 0, 8'(8'h10 + i));
      cyc(0, 0, 64'd0, 64'd0, 1);
    end
    head("fy_empty", 0, 0, 8'h00);

    // watchdog trips exactly one cycle after reaching the limit
    do_reset();
    for (int i = 0; i < 1024; i++) cyc(0, 0, 64'd0, 64'd0, 0);
    check("wd_1024", 64'(timeout_o), 64'd0);
    cyc(0, 0, 64'd0, 64'd0, 0);
    check("wd_1025", 64'(timeout_o), 64'd1);
    do_reset();
    for (int i = 0; i < 1022; i++) cyc(0, 0, 64'd0, 64'd0, 0);
    cyc(1, 0, 64'd0, 64'd0, 0);
    cyc(0, 0, 64'd0, 64'd0, 0);
    cyc(0, 0, 64'd0, 64'd0, 0);
    check("wd_saved", 64'(timeout_o), 64'd0);

    // reset from DONE with a full, overflowed FIFO overrides a same-cycle commit
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 1, PINT, 64'(i), 0);
    cyc(1, 1, STAT, 64'h0000_0007, 0);
    check("r_pre_done", 64'(done_o), 64'd1);
    check("r_pre_ovf", 64'(overflow_o), 64'd1);
    reset_i = 1'b1;
    #1;
    check("r_hold_pv", 64'(print_v_o), 64'd0);
    cmt_v_i = 1'b1; cmt_store_v_i = 1'b1; cmt_addr_i = STAT; cmt_data_i = 64'hFFFF_0001;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    cmt_v_i = 1'b0; cmt_store_v_i = 1'b0; cmt_addr_i = '0; cmt_data_i = '0;
    check("r_done", 64'(done_o), 64'd0);
    check("r_fail", 64'(fail_o), 64'd0);
    check("r_pv", 64'(print_v_o), 64'd0);
    check("r_ovf", 64'(overflow_o), 64'd0);
    check("r_cnt", instr_count_o, 64'd0);
    check("r_tnum", 64'(test_num_o), 64'd0);
    cyc(1, 1, STAT, 64'h0000_0003, 0);
    check("r2_done", 64'(done_o), 64'd1);
    check("r2_pass", 64'(pass_o), 64'd1);
    check("r2_tnum", 64'(test_num_o), 64'h3);
    check("r2_cnt", instr_count_o, 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bp_be_host_mmio_monitor.md
BP_BE_HOST_MMIO_MONITOR -- requirements
Module: bp_be_host_mmio_monitor

Interface
REQ-001 SHALL have parameter print_fifo_els_p, default 4, meaning the print FIFO depth (power of 2, ≥2).
REQ-002 SHALL have parameter timeout_cycles_p, default 1024, meaning the no-commit cycles before timeout.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on posedge.
REQ-004 SHALL have port reset_i, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port cmt_v_i, input, 1 bit: one instruction committed this cycle (not bubble, miss, roll or poison).
REQ-006 SHALL have port cmt_store_v_i, input, 1 bit: the committed instruction is a store; qualified by cmt_v_i.
REQ-007 SHALL have port cmt_addr_i, input, 64 bits: store effective address (rs1+imm).
REQ-008 SHALL have port cmt_data_i, input, 64 bits: store data (rs2 operand).
REQ-009 SHALL have ports print_v_o (output, 1), print_data_o (output, 8), print_is_int_o (output, 1; 1=decimal, 0=character) and print_yumi_i (input, 1): FIFO head and dequeue.
REQ-010 SHALL have outputs done_o, pass_o, fail_o, err_o (1 each), test_num_o (16), instr_count_o (64), timeout_o (1) and overflow_o (1).

Function
REQ-011 SHALL decode a host access as cmt_v_i & cmt_store_v_i & cmt_addr_i equal to a full 64-bit constant.
REQ-012 SHALL, on a store to 0x0000_0000_C00D_EAD0, set done_o the next cycle and latch test_num_o=cmt_data_i[15:0].
REQ-013 SHALL, for that store, set pass_o if cmt_data_i[31:16]==16'h0000, set fail_o if ==16'hFFFF, and otherwise set err_o; exactly one of these is set.
REQ-014 SHALL hold done_o, pass_o, fail_o, err_o and test_num_o sticky until reset; later status stores are ignored.
REQ-015 SHALL treat done state as an FSM RUN->DONE; in DONE, print enqueues and instr_count_o updates stop, while FIFO dequeue continues.
REQ-016 SHALL, on a store to 0x8FFF_FFFF, enqueue {is_int=1, data=cmt_data_i[7:0]}; on a store to 0x8FFF_EFFF, enqueue {is_int=0, data=cmt_data_i[7:0]}.
REQ-017 SHALL present the FIFO head on print_v_o/print_data_o/print_is_int_o; an enqueued entry is first visible the cycle after the commit.
REQ-018 SHALL dequeue the head when print_yumi_i is asserted; print_yumi_i while print_v_o=0 is illegal and SHALL be ignored.
REQ-019 SHALL accept an enqueue when full only if print_yumi_i is asserted the same cycle; otherwise it SHALL drop the entry and set overflow_o sticky.
REQ-020 SHALL support a simultaneous enqueue and dequeue when empty: no bypass; the new entry appears the next cycle.
REQ-021 SHALL keep FIFO pointers wrapping modulo print_fifo_els_p, with a separate full/empty indication (no wasted slot).
REQ-022 SHALL increment instr_count_o by 1 per cycle with cmt_v_i in RUN, including the terminating status store; it wraps at 2^64.
REQ-023 SHALL keep a watchdog counter that clears on cmt_v_i and otherwise increments, saturating at timeout_cycles_p.
REQ-024 SHALL set timeout_o sticky the cycle after the watchdog counter reaches timeout_cycles_p, and SHALL freeze the watchdog in DONE.
REQ-025 SHALL treat other stores and non-store commits as counted only, with no other effect.

Reset
REQ-026 SHALL, while reset_i is high, drive all outputs to 0, set the FSM to RUN, empty the FIFO and clear all counters and sticky flags.
REQ-027 SHALL let reset_i asserted mid-operation (DONE, full FIFO, pending timeout) override all other events that cycle.
REQ-028 SHALL ignore commit inputs in any cycle where reset_i is high.

Verification
REQ-029 SHALL be covered by: 3 plain commits, then a store to C00DEAD0 with data 0x0000_0005 -> next cycle done=1, pass=1, test_num=0x0005, instr_count=4; further commits leave count at 4.
REQ-030 SHALL be covered by: a store to C00DEAD0 with data 0xFFFF_0002 -> fail=1, test_num=0x0002; then with data 0x1234_0001 after reset -> err=1, pass=fail=0.
REQ-031 SHALL be covered by: stores of 0x41 to 8FFFEFFF and then 0x07 to 8FFFFFFF, with yumi held low -> head {0,0x41}; one yumi -> head {1,0x07}; a second yumi -> print_v_o=0.
REQ-032 SHALL be covered by: 5 print stores with depth 4 and no yumi -> 4 entries, overflow=1; when full, an enqueue with yumi in the same cycle -> still 4 entries, no overflow.
REQ-033 SHALL be covered by: no cmt_v_i for 1024 cycles -> timeout=1 on cycle 1025; a commit at cycle 1023 instead -> no timeout.
REQ-034 SHALL be covered by: reset asserted while in DONE with a full FIFO -> all outputs 0 the next cycle; a following status store is accepted again.
